booth_divider: RTL and testbench

- Sequential signed two's-complement divider, the inverse of the combinational booth multiplier: multiplier takes x, y and produces p; this block takes dividend, divisor and produces quotient, remainder.
- Used by the floating-point datapath for mantissa division.
- Also used to check multiplier results in self-checking benches.
- Radix-2 restoring iteration on magnitudes, one quotient bit per clock, sign fix-up at the end.

---
 rtl/fp_div_pkg.sv | 12 +
 rtl/div_abs_neg.sv | 10 +
 rtl/booth_divider.sv | 137 +++++++++++++
 tb/tb_booth_divider.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package fp_div_pkg;
    localparam int DIV_W = 25;
    localparam int CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;
endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate, used for magnitudes and sign fix-up.
module div_abs_neg #(
    parameter int W = 25
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + 1'b1) : i_val;
endmodule

// File: rtl/booth_divider.sv
// Signed radix-2 restoring divider: one quotient bit per clock on magnitudes,
// sign fix-up and divide-by-zero / overflow overrides in the final cycle.
module booth_divider
    import fp_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);
    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_dvd;
    logic [W-1:0]       r_dsr;
    logic [W:0]         r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sq;
    logic               r_sr;
    logic [W-1:0]       r_q;
    logic [W-1:0]       r_r;
    logic               r_done;
    logic               r_dz;
    logic               r_ov;

    logic [W-1:0]       w_abs_a;
    logic [W-1:0]       w_abs_b;
    logic [W-1:0]       w_q_fix;
    logic [W-1:0]       w_r_fix;
    logic [W:0]         w_shift;
    logic [W:0]         w_trial;
    logic               w_ov;
    logic               w_rem_unused;

    div_abs_neg #(.W(W)) u_abs_a (.i_val(r_a), .i_neg(r_a[W-1]), .o_val(w_abs_a));
    div_abs_neg #(.W(W)) u_abs_b (.i_val(r_b), .i_neg(r_b[W-1]), .o_val(w_abs_b));
    div_abs_neg #(.W(W)) u_fix_q (.i_val(r_dvd), .i_neg(r_sq), .o_val(w_q_fix));
    div_abs_neg #(.W(W)) u_fix_r (.i_val(r_rem[W-1:0]), .i_neg(r_sr), .o_val(w_r_fix));

    // Kept remainder is always below the divisor magnitude, so its top bit stays 0
    assign w_rem_unused = r_rem[W];
    assign w_shift      = {r_rem[W-1:0], r_dvd[W-1]};
    assign w_trial      = w_shift - {1'b0, r_dsr};
    assign w_ov         = (r_a == {1'b1, {(W-1){1'b0}}}) && (r_b == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = PREP;
            PREP:    w_next = ITER;
            ITER:    if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_sq   <= 1'b0;
            r_sr   <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_ov   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a  <= dividend;
                        r_b  <= divisor;
                        r_dz <= 1'b0;
                        r_ov <= 1'b0;
                    end
                end
                PREP: begin
                    r_dvd <= w_abs_a;
                    r_dsr <= w_abs_b;
                    r_rem <= '0;
                    r_sq  <= r_a[W-1] ^ r_b[W-1];
                    r_sr  <= r_a[W-1];
                    r_dz  <= (r_b == '0);
                    r_ov  <= w_ov;
                    r_cnt <= CNT_W'(W-1);
                end
                ITER: begin
                    r_rem <= w_trial[W] ? w_shift : w_trial;
                    r_dvd <= {r_dvd[W-2:0], ~w_trial[W]};
                    r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_q <= '1;
                        r_r <= r_a;
                    end else if (r_ov) begin
                        r_q <= r_a;
                        r_r <= '0;
                    end else begin
                        r_q <= w_q_fix;
                        r_r <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE) | r_done;
    assign done        = r_done;
    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;
endmodule

// File: tb/tb_booth_divider.sv
// Directed-vector bench for booth_divider: results, latency, flags,
// back-to-back accept, ignored start while busy and mid-operation reset.
module tb_booth_divider;
    localparam int W = 25;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    booth_divider #(.W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge; start is sampled at the following posedge.
    // Returns at the negedge of the done cycle so a caller can chain ops.
    task automatic do_op(input string tag,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov,
                         input int pulse_k);
        int lat;
        logic bok;
        lat = -1;
        bok = 1'b1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                chk({tag, "_pulse"}, done, 0);
            end
            if (k == pulse_k) begin
                start    = 1'b1;
                dividend = 25'h0000123;
                divisor  = 25'h0000007;
            end
            if (k == pulse_k + 1) start = 1'b0;
            if (k >= 1 && !busy) bok = 1'b0;
            if (k >= 1 && done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 27);
        chk({tag, "_busy"}, bok, 1);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_by_zero, edz);
        chk({tag, "_ov"}, overflow, eov);
    endtask

    initial begin
        logic seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_ov", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("30/6", 25'd30, 25'd6, 25'd5, 25'd0, 0, 0, -1);
        do_op("b2b_5/3", 25'd5, 25'd3, 25'd1, 25'd2, 0, 0, -1);
        repeat (3) @(negedge clk);
        chk("hold_done", done, 0);
        chk("hold_busy", busy, 0);
        chk("hold_q", quotient, 1);
        chk("hold_r", remainder, 2);

        do_op("-7/2", 25'h1FFFFF9, 25'd2, 25'h1FFFFFD, 25'h1FFFFFF, 0, 0, -1);
        @(negedge clk);
        do_op("7/-2", 25'd7, 25'h1FFFFFE, 25'h1FFFFFD, 25'd1, 0, 0, -1);
        @(negedge clk);
        do_op("-7/-2", 25'h1FFFFF9, 25'h1FFFFFE, 25'd3, 25'h1FFFFFF, 0, 0, -1);
        @(negedge clk);
        do_op("div0", 25'h0777777, 25'd0, 25'h1FFFFFF, 25'h0777777, 1, 0, -1);
        @(negedge clk);
        do_op("ovf", 25'h1000000, 25'h1FFFFFF, 25'h1000000, 25'd0, 0, 1, -1);
        @(negedge clk);
        do_op("min/1", 25'h1000000, 25'd1, 25'h1000000, 25'd0, 0, 0, -1);
        @(negedge clk);
        do_op("ign_start", 25'd100, 25'd7, 25'd14, 25'd2, 0, 0, 10);
        @(negedge clk);

        // Abort with a reset in the middle of the iteration
        dividend = 25'd1000;
        divisor  = 25'd3;
        start    = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dz", div_by_zero, 0);
        chk("abort_ov", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_nodone", seen, 0);

        do_op("post_rst", 25'd1000, 25'd3, 25'd333, 25'd1, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
